lsu_bus_master: RTL and testbench
=================================

Name: lsu_bus_master

Overview:
- Load/store unit on the CPU side of the data-memory bus. It is the initiator; the data memory is the responder.
- Accepts one word/half/byte access at a time from the MEM pipeline stage and checks alignment.
- Drives a req/gnt/rvalid bus with word address, byte enables and lane-replicated store data.
- Extracts and zero- or sign-extends load data, and stalls the pipeline until the access completes.

Parameters:
- TIMEOUT, 255: max cycles from entering REQ to rvalid before a bus-error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  reset (synchronous, active-high)
- cpu_valid  in  1  access request; held stable while cpu_stall=1
- cpu_we  in  1  1=store, 0=load
- cpu_op  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word)
- cpu_signed  in  1  sign-extend a half/byte load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_stall  out  1  freeze the pipeline
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  32  extended load data; valid while cpu_done=1, 0 for stores
- cpu_exc  out  2  valid while cpu_done=1: 00 none, 01 AdEL, 10 AdES, 11 bus timeout
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address, bits [1:0]=0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response / write acknowledge
- mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- Reset: state=IDLE. All outputs 0 (cpu_stall, cpu_done, cpu_rdata, cpu_exc, mem_*). Timeout counter=0.
- Reset mid-transaction abandons the transaction. A later gnt or rvalid seen in IDLE is ignored.
- cpu_stall = cpu_valid & ~cpu_done (combinational). It is 0 in the RESP cycle.
- IDLE, cpu_valid=1 (cycle c0):
  - Latch we, op, signed, addr[1:0], wdata.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP, exc=AdEL for a load or AdES for a store. mem_req stays 0.
  - Otherwise: go to REQ. In c1, mem_req=1, with mem_addr={addr[31:2],2'b00}, mem_we, mem_be and mem_wdata registered.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- Store data lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- REQ: mem_req and all mem_* stay stable until mem_gnt=1.
  - gnt without rvalid: go to WAIT, mem_req=0 next cycle.
  - gnt and rvalid in the same cycle: go directly to RESP.
- WAIT: on mem_rvalid, register the result and go to RESP. rvalid is ignored in any state other than REQ-with-gnt or WAIT.
- RESP: lasts exactly one cycle. cpu_done=1 with cpu_rdata and cpu_exc valid, then IDLE. A new request may be accepted in the following cycle.
- Load extraction uses the latched addr[1:0]:
  - half: addr[1] ? rdata[31:16] : rdata[15:0]
  - byte: lane addr[1:0]
  - Zero-extend if cpu_signed=0, else replicate the top bit.
- Timeout:
  - Counter clears on leaving IDLE and increments each cycle in REQ/WAIT.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT: drop mem_req, go to RESP with exc=11 and rdata=0.
  - rvalid arriving in the same cycle as expiry wins: normal completion.
- Latency: aligned access with gnt and rvalid both in c1 gives done in c2. Misaligned access gives done in c1.

Decomposition:
- Shared package: size encodings (WORD/HALF/BYTE), exception codes, FSM state encoding.
- One sub-module, lsu_load_align (combinational): rdata, offset, size, signed -> extended data. Reusable by the DM responder.

Test Plan:
- lb signed, addr 0x00001003, gnt+rvalid in c1, rdata 0x80FF1234 -> c2: done=1, cpu_rdata=0xFFFFFF80, exc=00.
- sh, addr 0x00001002, wdata 0x1234BEEF -> c1: mem_req=1, mem_addr=0x00001000, be=1100, mem_wdata=0xBEEFBEEF, mem_we=1. Ack via rvalid gives done with rdata=0.
- lw, addr 0x00001002 -> c1: done=1, exc=01, mem_req never asserted. Same access as sw -> exc=10.
- lhu, addr 0x00002002, gnt delayed 3 cycles, rvalid 2 cycles after gnt, rdata 0x9ABC5678:
  - mem_req held with stable address/be until gnt.
  - stall=1 throughout.
  - done one cycle after rvalid with cpu_rdata=0x00009ABC.
- TIMEOUT=4, gnt never asserted -> done with exc=11 exactly 4 cycles after REQ entry, mem_req drops, stall clears. A late gnt/rvalid is ignored.
- reset asserted in WAIT, rvalid the next cycle -> all outputs 0, no done pulse. A following lw at 0x0 completes normally.

Source files
------------

// File: rtl/lsu_bus_master_pkg.sv
// Shared types and helpers for the load/store unit and its data-memory bus.
package lsu_bus_master_pkg;

   // Access size as carried on cpu_op; the reserved encoding 2'b11 decodes to a word.
   typedef enum logic [1:0] {
      SzWord = 2'b00,
      SzHalf = 2'b01,
      SzByte = 2'b10
   } lsu_size_e;

   // Exception code reported alongside cpu_done.
   typedef enum logic [1:0] {
      ExcNone   = 2'b00,
      ExcAdEL   = 2'b01,
      ExcAdES   = 2'b10,
      ExcBusTmo = 2'b11
   } lsu_exc_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StWait = 2'b10,
      StResp = 2'b11
   } lsu_state_e;

   function automatic lsu_size_e size_decode(input logic [1:0] op);
      case (op)
         2'b01:   return SzHalf;
         2'b10:   return SzByte;
         default: return SzWord;
      endcase
   endfunction

   function automatic logic misaligned(input lsu_size_e size, input logic [1:0] off);
      case (size)
         SzHalf:  return off[0];
         SzByte:  return 1'b0;
         default: return off != 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input lsu_size_e size, input logic [1:0] off);
      case (size)
         SzHalf:  return off[1] ? 4'b1100 : 4'b0011;
         SzByte:  return 4'b0001 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store data across every lane it could land in.
   function automatic logic [31:0] lane_data(input lsu_size_e size, input logic [31:0] wdata);
      case (size)
         SzHalf:  return {2{wdata[15:0]}};
         SzByte:  return {4{wdata[7:0]}};
         default: return wdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// req/gnt/rvalid data-memory bus between the LSU (master) and the memory (slave).
interface lsu_bus_master_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed half/byte out of a read word and zero- or sign-extends it.
module lsu_load_align
   import lsu_bus_master_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  lsu_size_e   size_i,
   input  logic        signed_i,
   output logic [31:0] data_o
);

   logic [15:0] half_w;
   logic [7:0]  byte_w;

   // Lane select followed by extension of the selected field's top bit.
   always_comb begin
      half_w = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      byte_w = rdata_i[{offset_i, 3'b000} +: 8];
      case (size_i)
         SzHalf:  data_o = {{16{signed_i & half_w[15]}}, half_w};
         SzByte:  data_o = {{24{signed_i & byte_w[7]}}, byte_w};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit: one access at a time from MEM, alignment check, bus transfer,
// load extraction and a pipeline stall until the access completes.
module lsu_bus_master
   import lsu_bus_master_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255  // 0 disables the bus timeout
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_valid_i,
   input  logic                    cpu_we_i,
   input  logic [1:0]              cpu_op_i,
   input  logic                    cpu_signed_i,
   input  logic [31:0]             cpu_addr_i,
   input  logic [31:0]             cpu_wdata_i,
   output logic                    cpu_stall_o,
   output logic                    cpu_done_o,
   output logic [31:0]             cpu_rdata_o,
   output logic [1:0]              cpu_exc_o,
   lsu_bus_master_if.master        bus
);

   lsu_state_e  state_q, state_d;
   lsu_size_e   size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  off_q, off_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   lsu_exc_e    exc_q, exc_d;
   logic [31:0] cnt_q, cnt_d;

   lsu_size_e   cpu_size;
   logic [31:0] cnt_inc;
   logic        tmo_hit;
   logic [31:0] load_data;

   assign cpu_size = size_decode(cpu_op_i);
   assign cnt_inc  = cnt_q + 32'd1;
   // Expiry fires in the cycle the counter would reach TIMEOUT, so the request is
   // outstanding for exactly TIMEOUT cycles before the error response.
   assign tmo_hit  = (TIMEOUT != 0) && (cnt_inc == TIMEOUT);

   lsu_load_align u_load_align (
      .rdata_i  (bus.mem_rdata),
      .offset_i (off_q),
      .size_i   (size_q),
      .signed_i (sgn_q),
      .data_o   (load_data)
   );

   // Next-state and datapath capture for the access FSM.
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      off_d   = off_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      exc_d   = exc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_valid_i) begin
               size_d  = cpu_size;
               sgn_d   = cpu_signed_i;
               off_d   = cpu_addr_i[1:0];
               cnt_d   = '0;
               rdata_d = '0;
               if (misaligned(cpu_size, cpu_addr_i[1:0])) begin
                  exc_d   = cpu_we_i ? ExcAdES : ExcAdEL;
                  state_d = StResp;
               end else begin
                  exc_d   = ExcNone;
                  we_d    = cpu_we_i;
                  addr_d  = {cpu_addr_i[31:2], 2'b00};
                  be_d    = byte_en(cpu_size, cpu_addr_i[1:0]);
                  wdata_d = lane_data(cpu_size, cpu_wdata_i);
                  state_d = StReq;
               end
            end
         end
         StReq, StWait: begin
            cnt_d = cnt_inc;
            // A response in the expiry cycle still completes normally.
            if (bus.mem_rvalid && (bus.mem_gnt || state_q == StWait)) begin
               rdata_d = we_q ? '0 : load_data;
               exc_d   = ExcNone;
               state_d = StResp;
            end else if (tmo_hit) begin
               rdata_d = '0;
               exc_d   = ExcBusTmo;
               state_d = StResp;
            end else if (state_q == StReq && bus.mem_gnt) begin
               state_d = StWait;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and captured-access registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         size_q  <= SzWord;
         sgn_q   <= 1'b0;
         off_q   <= 2'b00;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         exc_q   <= ExcNone;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         off_q   <= off_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cpu_done_o  = (state_q == StResp);
   assign cpu_stall_o = cpu_valid_i & ~cpu_done_o;
   assign cpu_rdata_o = cpu_done_o ? rdata_q : '0;
   assign cpu_exc_o   = cpu_done_o ? exc_q : ExcNone;

   assign bus.mem_req   = (state_q == StReq);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: table of directed accesses, hand sequences for
// reset/timeout corners, and random accesses against an arithmetic model.
module tb_lsu_bus_master;

   typedef struct {
      logic        we;
      logic [1:0]  op;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          g;          // cycles in REQ before gnt
      int          r;          // cycles from gnt to rvalid (0 = same cycle)
      logic [31:0] rword;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_exc;
      int          exp_k;      // cycle of done, counted from the cycle valid is first seen
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_valid = 1'b0, cpu_we = 1'b0, cpu_signed = 1'b0;
   logic [1:0]  cpu_op = 2'b00;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] mrdata = '0;
   logic        sel = 1'b0;  // 0: TIMEOUT=255 instance, 1: TIMEOUT=4 instance

   int n_cmp = 0;
   int n_fail = 0;

   logic        stall_a, done_a, stall_t, done_t;
   logic [31:0] rdata_a, rdata_t;
   logic [1:0]  exc_a, exc_t;

   lsu_bus_master_if bus_a ();
   lsu_bus_master_if bus_t ();

   assign bus_a.mem_gnt    = gnt;
   assign bus_a.mem_rvalid = rvalid;
   assign bus_a.mem_rdata  = mrdata;
   assign bus_t.mem_gnt    = gnt;
   assign bus_t.mem_rvalid = rvalid;
   assign bus_t.mem_rdata  = mrdata;

   lsu_bus_master dut_a (
      .clk(clk), .reset(reset), .cpu_valid_i(cpu_valid), .cpu_we_i(cpu_we), .cpu_op_i(cpu_op),
      .cpu_signed_i(cpu_signed), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_stall_o(stall_a), .cpu_done_o(done_a), .cpu_rdata_o(rdata_a), .cpu_exc_o(exc_a),
      .bus(bus_a)
   );

   lsu_bus_master #(.TIMEOUT(4)) dut_t (
      .clk(clk), .reset(reset), .cpu_valid_i(cpu_valid), .cpu_we_i(cpu_we), .cpu_op_i(cpu_op),
      .cpu_signed_i(cpu_signed), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_stall_o(stall_t), .cpu_done_o(done_t), .cpu_rdata_o(rdata_t), .cpu_exc_o(exc_t),
      .bus(bus_t)
   );

   wire        o_stall = sel ? stall_t : stall_a;
   wire        o_done  = sel ? done_t : done_a;
   wire [31:0] o_rdata = sel ? rdata_t : rdata_a;
   wire [1:0]  o_exc   = sel ? exc_t : exc_a;
   wire        o_req   = sel ? bus_t.mem_req : bus_a.mem_req;
   wire        o_we    = sel ? bus_t.mem_we : bus_a.mem_we;
   wire [31:0] o_addr  = sel ? bus_t.mem_addr : bus_a.mem_addr;
   wire [3:0]  o_be    = sel ? bus_t.mem_be : bus_a.mem_be;
   wire [31:0] o_wdata = sel ? bus_t.mem_wdata : bus_a.mem_wdata;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " ctl"}, {29'd0, o_stall, o_done, o_req}, 32'd0);
      chk({tag, " rdata/exc"}, {o_rdata[29:0] | 30'(o_rdata[31:30]), o_exc}, 32'd0);
      chk({tag, " bus"}, o_addr | o_wdata | {27'd0, o_we, o_be}, 32'd0);
   endtask

   function automatic vec_t mk(logic we, logic [1:0] op, logic sgn, logic [31:0] addr,
                               logic [31:0] wdata, int g, int r, logic [31:0] rword,
                               logic [31:0] exp_rdata, logic [1:0] exp_exc, int exp_k,
                               logic [3:0] exp_be, logic [31:0] exp_wdata);
      vec_t v;
      v.we = we; v.op = op; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.g = g; v.r = r;
      v.rword = rword; v.exp_rdata = exp_rdata; v.exp_exc = exp_exc; v.exp_k = exp_k;
      v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   // Reference: sizes in bytes, shifts and masks; timing from when rvalid lands.
   function automatic vec_t model(logic we, logic [1:0] op, logic sgn, logic [31:0] addr,
                                  logic [31:0] wdata, int g, int r, logic [31:0] rword, int tmo);
      vec_t v;
      int n, off;
      logic [31:0] x, m;
      v = mk(we, op, sgn, addr, wdata, g, r, rword, 32'd0, 2'd0, 0, 4'd0, 32'd0);
      n = (op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 4;
      off = int'(addr[1:0]);
      v.exp_be = 4'(((1 << n) - 1) << off);
      for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
      if ((off % n) != 0) begin
         v.exp_exc = we ? 2'd2 : 2'd1;
         v.exp_k = 1;
      end else if (tmo == 0 || 1 + g + r <= tmo) begin
         x = rword >> (8 * off);
         if (n < 4) begin
            m = (32'd1 << (8 * n)) - 32'd1;
            x = x & m;
            if (sgn && x[8*n-1]) x = x | ~m;
         end
         v.exp_rdata = we ? 32'd0 : x;
         v.exp_k = 2 + g + r;
      end else begin
         v.exp_exc = 2'd3;
         v.exp_k = 1 + tmo;
      end
      return v;
   endfunction

   task automatic run_access(input vec_t v, input string tag);
      bit mis;
      int req_last;
      mis = (v.exp_exc == 2'd1) || (v.exp_exc == 2'd2);
      req_last = mis ? 0 : (((1 + v.g) < (v.exp_k - 1)) ? (1 + v.g) : (v.exp_k - 1));
      for (int k = 0; k <= v.exp_k; k++) begin
         @(negedge clk);
         cpu_valid = 1'b1; cpu_we = v.we; cpu_op = v.op; cpu_signed = v.sgn;
         cpu_addr = v.addr; cpu_wdata = v.wdata;
         gnt = !mis && (k == 1 + v.g);
         rvalid = !mis && (k == 1 + v.g + v.r);
         mrdata = v.rword;
         #1;
         chk({tag, " stall/done/req"}, {29'd0, o_stall, o_done, o_req},
             {29'd0, k != v.exp_k, k == v.exp_k, k >= 1 && k <= req_last});
         if (k >= 1 && k <= req_last) begin
            chk({tag, " mem_addr"}, o_addr, {v.addr[31:2], 2'b00});
            chk({tag, " mem_be/we"}, {27'd0, o_we, o_be}, {27'd0, v.we, v.exp_be});
            chk({tag, " mem_wdata"}, o_wdata, v.exp_wdata);
         end
         if (k == v.exp_k) begin
            chk({tag, " rdata"}, o_rdata, v.exp_rdata);
            chk({tag, " exc"}, {30'd0, o_exc}, {30'd0, v.exp_exc});
         end
      end
   endtask

   task automatic idle_cycles(input int n, input logic g_v, input logic r_v, input string tag);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cpu_valid = 1'b0; gnt = g_v; rvalid = r_v;
         #1;
         chk({tag, " stall/done/req"}, {29'd0, o_stall, o_done, o_req}, 32'd0);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1; cpu_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_zero(tag);
   endtask

   vec_t tbl[13];

   initial begin
      vec_t v;
      // we op sgn addr wdata g r rword | rdata exc done_k be mem_wdata
      tbl[0]  = mk(0, 2, 1, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234,
                   32'hFFFF_FF80, 0, 2, 4'b1000, 32'h0);
      tbl[1]  = mk(1, 1, 0, 32'h0000_1002, 32'h1234_BEEF, 0, 1, 32'hDEAD_DEAD,
                   32'h0, 0, 3, 4'b1100, 32'hBEEF_BEEF);
      tbl[2]  = mk(0, 0, 0, 32'h0000_1002, 32'h0, 0, 0, 32'h0, 32'h0, 1, 1, 4'b0, 32'h0);
      tbl[3]  = mk(1, 0, 0, 32'h0000_1002, 32'h55, 0, 0, 32'h0, 32'h0, 2, 1, 4'b0, 32'h0);
      tbl[4]  = mk(0, 1, 0, 32'h0000_2002, 32'h0, 3, 2, 32'h9ABC_5678,
                   32'h0000_9ABC, 0, 7, 4'b1100, 32'h0);
      tbl[5]  = mk(0, 0, 0, 32'h0000_3000, 32'h0, 1, 0, 32'hCAFE_F00D,
                   32'hCAFE_F00D, 0, 3, 4'b1111, 32'h0);
      tbl[6]  = mk(0, 1, 1, 32'h0000_0010, 32'h0, 0, 0, 32'h0000_F00D,
                   32'hFFFF_F00D, 0, 2, 4'b0011, 32'h0);
      tbl[7]  = mk(0, 2, 0, 32'h0000_0021, 32'h0, 2, 1, 32'h1122_9944,
                   32'h0000_0099, 0, 5, 4'b0010, 32'h0);
      tbl[8]  = mk(1, 2, 0, 32'h0000_0042, 32'hFFFF_FFA5, 0, 0, 32'h0,
                   32'h0, 0, 2, 4'b0100, 32'hA5A5_A5A5);
      tbl[9]  = mk(0, 3, 1, 32'h0000_0008, 32'h0, 0, 3, 32'h8765_4321,
                   32'h8765_4321, 0, 5, 4'b1111, 32'h0);
      tbl[10] = mk(1, 1, 0, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 32'h0, 2, 1, 4'b0, 32'h0);
      tbl[11] = mk(0, 2, 1, 32'h0000_1002, 32'h0, 0, 0, 32'h007F_0000,
                   32'h0000_007F, 0, 2, 4'b0100, 32'h0);
      tbl[12] = mk(1, 0, 0, 32'h0000_0004, 32'h0123_4567, 1, 2, 32'h0,
                   32'h0, 0, 5, 4'b1111, 32'h0123_4567);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      sel = 1'b0;
      check_zero("reset A");
      sel = 1'b1;
      check_zero("reset T");
      sel = 1'b0;

      for (int i = 0; i < 13; i++) run_access(tbl[i], $sformatf("vec%0d", i));
      idle_cycles(1, 1'b0, 1'b0, "post-table idle");

      // Reset while waiting for rvalid; the late rvalid must be ignored.
      run_access(mk(0, 0, 0, 32'h100, 32'h0, 0, 9, 32'h0, 32'h0, 0, 11, 4'b1111, 32'h0),
                 "pre-reset") ;
      @(negedge clk);
      cpu_valid = 1'b1; cpu_op = 2'b00; cpu_we = 1'b0; cpu_addr = 32'h200;
      gnt = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      gnt = 1'b1;
      #1;
      chk("rstwait req", {31'd0, o_req}, 32'd1);
      @(negedge clk);
      gnt = 1'b0; cpu_valid = 1'b0; reset = 1'b1;
      #1;
      chk("rstwait in WAIT", {30'd0, o_done, o_req}, 32'd0);
      @(negedge clk);
      reset = 1'b0; rvalid = 1'b1; mrdata = 32'h1234_5678;
      #1;
      check_zero("rstwait after reset");
      @(negedge clk);
      rvalid = 1'b0;
      #1;
      check_zero("rstwait late rvalid");
      run_access(mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0BAD_F00D,
                    32'h0BAD_F00D, 0, 2, 4'b1111, 32'h0), "lw after reset");

      for (int i = 0; i < 30; i++) begin
         v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                   $urandom, 255);
         run_access(v, $sformatf("randA%0d", i));
      end

      sel = 1'b1;
      do_reset("reset before T");
      run_access(mk(0, 0, 0, 32'h500, 32'h0, 10, 0, 32'h0, 32'h0, 3, 5, 4'b1111, 32'h0),
                 "timeout no gnt");
      idle_cycles(3, 1'b1, 1'b1, "late gnt/rvalid");
      run_access(mk(0, 0, 0, 32'h504, 32'h0, 1, 2, 32'h7777_1111,
                    32'h7777_1111, 0, 5, 4'b1111, 32'h0), "rvalid at expiry");
      run_access(mk(1, 2, 0, 32'h509, 32'h3C, 3, 1, 32'h0, 32'h0, 3, 5, 4'b0010, 32'h3C3C_3C3C),
                 "gnt at expiry");
      idle_cycles(1, 1'b0, 1'b0, "post-timeout idle");

      for (int i = 0; i < 40; i++) begin
         v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                   $urandom, 4);
         run_access(v, $sformatf("randT%0d", i));
      end
      idle_cycles(2, 1'b0, 1'b0, "final idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
